sc_timing_ctrl: RTL

SC_TIMING_CTRL -- requirements
Module: sc_timing_ctrl

---
 rtl/sc_pkg.sv | 23 ++
 rtl/sc_timing_ctrl_if.sv | 21 ++
 rtl/sc_lock_fsm.sv | 86 ++++++++
 rtl/sc_timing_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared constants, lock state enum and defaults for the scanconverter timing controller
package sc_pkg;

    localparam logic [2:0] CFG_H_OUT    = 3'd0;
    localparam logic [2:0] CFG_H_OUT2   = 3'd1;
    localparam logic [2:0] CFG_V_OUT    = 3'd2;
    localparam logic [2:0] CFG_V_OUT2   = 3'd3;
    localparam logic [2:0] CFG_XY_OUT   = 3'd4;
    localparam logic [2:0] CFG_MISC     = 3'd5;
    localparam logic [2:0] CFG_SL       = 3'd6;
    localparam logic [2:0] CFG_SL2      = 3'd7;
    localparam int unsigned NUM_CFG     = 8;

    localparam int unsigned DEF_LOCK_FRAMES   = 4;
    localparam logic [23:0] DEF_FRAME_TIMEOUT = 24'd4_000_000;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_e;

endpackage

// File: rtl/sc_timing_ctrl_if.sv
// rtl/sc_timing_ctrl_if.sv - configuration write/commit bus into the timing controller
interface sc_timing_ctrl_if;
    logic        cfg_wr_i;
    logic [2:0]  cfg_addr_i;
    logic [31:0] cfg_wdata_i;
    logic        cfg_commit_i;

    modport master (
        output cfg_wr_i,
        output cfg_addr_i,
        output cfg_wdata_i,
        output cfg_commit_i
    );

    modport slave (
        input cfg_wr_i,
        input cfg_addr_i,
        input cfg_wdata_i,
        input cfg_commit_i
    );
endinterface

// File: rtl/sc_lock_fsm.sv
// rtl/sc_lock_fsm.sv - frame lock tracker: counts resync-free frames and resyncs seen while locked
module sc_lock_fsm
    import sc_pkg::*;
#(
    parameter int unsigned LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic       PCLK_OUT_i,
    input  logic       reset_i,
    input  logic       fs_i,
    input  logic       resync_edge_i,
    input  logic       apply_i,
    input  logic       timeout_i,
    output logic       lock_o,
    output logic [7:0] resync_cnt_o
);

    localparam logic [3:0] LAST_GOOD = 4'(LOCK_FRAMES - 1);

    lock_state_e state_q, state_d;
    logic [3:0]  gcnt_q, gcnt_d;
    logic [7:0]  rcnt_q, rcnt_d;
    logic        lock_q;

    // apply/timeout override everything; within a state a resync edge beats a frame start
    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        rcnt_d  = rcnt_q;
        if (apply_i || timeout_i) begin
            state_d = ST_UNLOCKED;
            gcnt_d  = 4'd0;
        end else begin
            case (state_q)
                ST_UNLOCKED: begin
                    if (fs_i) begin
                        state_d = ST_ACQUIRE;
                        gcnt_d  = 4'd0;
                    end
                end
                ST_ACQUIRE: begin
                    if (resync_edge_i) begin
                        gcnt_d = 4'd0;
                    end else if (fs_i) begin
                        if (gcnt_q == LAST_GOOD) begin
                            state_d = ST_LOCKED;
                            gcnt_d  = 4'd0;
                        end else begin
                            gcnt_d = gcnt_q + 4'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (resync_edge_i) begin
                        state_d = ST_ACQUIRE;
                        gcnt_d  = 4'd0;
                        if (rcnt_q != 8'hFF) begin
                            rcnt_d = rcnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_UNLOCKED;
                    gcnt_d  = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge PCLK_OUT_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_UNLOCKED;
            gcnt_q  <= 4'd0;
            rcnt_q  <= 8'd0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
            rcnt_q  <= rcnt_d;
            lock_q  <= (state_d == ST_LOCKED);
        end
    end

    assign lock_o       = lock_q;
    assign resync_cnt_o = rcnt_q;

endmodule

// File: rtl/sc_timing_ctrl.sv
// rtl/sc_timing_ctrl.sv - shadowed scanconverter config with frame-aligned commit, watchdog and lock tracking
module sc_timing_ctrl
    import sc_pkg::*;
#(
    parameter int unsigned LOCK_FRAMES   = DEF_LOCK_FRAMES,
    parameter logic [23:0] FRAME_TIMEOUT = DEF_FRAME_TIMEOUT
) (
    input  logic              PCLK_OUT_i,
    input  logic              reset_i,
    sc_timing_ctrl_if.slave   cfg,
    input  logic              VSYNC_i,
    input  logic              resync_strobe_i,
    output logic [31:0]       h_out_config_o,
    output logic [31:0]       h_out_config2_o,
    output logic [31:0]       v_out_config_o,
    output logic [31:0]       v_out_config2_o,
    output logic [31:0]       xy_out_config_o,
    output logic [31:0]       misc_config_o,
    output logic [31:0]       sl_config_o,
    output logic [31:0]       sl_config2_o,
    output logic              commit_pending_o,
    output logic              lock_o,
    output logic [7:0]        resync_cnt_o,
    output logic              timeout_o
);

    logic [31:0] shadow_q [NUM_CFG];
    logic [31:0] active_q [NUM_CFG];
    logic        vs_prev_q;
    logic        rs_prev_q;
    logic        pending_q, pending_d;
    logic        timeout_q, timeout_d;
    logic [23:0] wd_q, wd_d;

    logic fs;
    logic resync_edge;
    logic wd_hit;
    logic apply;

    assign fs          = ~VSYNC_i & vs_prev_q;
    assign resync_edge = resync_strobe_i & ~rs_prev_q;
    assign wd_hit      = (wd_q == FRAME_TIMEOUT - 24'd1);
    assign apply       = pending_q & (fs | wd_hit);

    // a commit landing on the apply cycle is absorbed by the pending request being served
    always_comb begin
        pending_d = pending_q;
        timeout_d = timeout_q;
        wd_d      = wd_q + 24'd1;
        if (apply) begin
            pending_d = 1'b0;
        end else if (cfg.cfg_commit_i) begin
            pending_d = 1'b1;
        end
        if (wd_hit) begin
            timeout_d = 1'b1;
        end else if (cfg.cfg_commit_i) begin
            timeout_d = 1'b0;
        end
        if (fs || wd_hit) begin
            wd_d = 24'd0;
        end
    end

    always_ff @(posedge PCLK_OUT_i or posedge reset_i) begin
        if (reset_i) begin
            vs_prev_q <= 1'b1;
            rs_prev_q <= 1'b0;
            pending_q <= 1'b0;
            timeout_q <= 1'b0;
            wd_q      <= 24'd0;
        end else begin
            vs_prev_q <= VSYNC_i;
            rs_prev_q <= resync_strobe_i;
            pending_q <= pending_d;
            timeout_q <= timeout_d;
            wd_q      <= wd_d;
        end
    end

    // active copies take the shadow value from before any same-edge write
    always_ff @(posedge PCLK_OUT_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                shadow_q[i] <= 32'd0;
                active_q[i] <= 32'd0;
            end
        end else begin
            if (cfg.cfg_wr_i) begin
                shadow_q[cfg.cfg_addr_i] <= cfg.cfg_wdata_i;
            end
            if (apply) begin
                for (int i = 0; i < NUM_CFG; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    sc_lock_fsm #(
        .LOCK_FRAMES (LOCK_FRAMES)
    ) u_lock_fsm (
        .PCLK_OUT_i    (PCLK_OUT_i),
        .reset_i       (reset_i),
        .fs_i          (fs),
        .resync_edge_i (resync_edge),
        .apply_i       (apply),
        .timeout_i     (wd_hit),
        .lock_o        (lock_o),
        .resync_cnt_o  (resync_cnt_o)
    );

    assign h_out_config_o   = active_q[CFG_H_OUT];
    assign h_out_config2_o  = active_q[CFG_H_OUT2];
    assign v_out_config_o   = active_q[CFG_V_OUT];
    assign v_out_config2_o  = active_q[CFG_V_OUT2];
    assign xy_out_config_o  = active_q[CFG_XY_OUT];
    assign misc_config_o    = active_q[CFG_MISC];
    assign sl_config_o      = active_q[CFG_SL];
    assign sl_config2_o     = active_q[CFG_SL2];
    assign commit_pending_o = pending_q;
    assign timeout_o        = timeout_q;

endmodule
